// File: rtl/hack_ctrl_seq_if.sv
// hack_ctrl_seq_if: ROM, RAM and ALU handshake bundle between the Hack sequencer (master) and its environment (slave).
interface hack_ctrl_seq_if #(parameter int ADDR_W = 15);
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;
  logic              instr_valid;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [15:0]       mem_rdata;
  logic              mem_wr_req;
  logic              mem_wr_ack;
  logic [15:0]       mem_wdata;
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic [5:0]        alu_ctl;
  logic [15:0]       alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic              retired;
  logic              illegal;
  modport master (
    output instr_addr, instr_ready, mem_addr, mem_rd_req, mem_wr_req, mem_wdata,
           alu_x, alu_y, alu_ctl, retired, illegal,
    input  instr_valid, instr, mem_rd_ack, mem_rdata, mem_wr_ack, alu_out, alu_zr, alu_ng
  );
  modport slave (
    input  instr_addr, instr_ready, mem_addr, mem_rd_req, mem_wr_req, mem_wdata,
           alu_x, alu_y, alu_ctl, retired, illegal,
    output instr_valid, instr, mem_rd_ack, mem_rdata, mem_wr_ack, alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_ctrl_seq.sv
// hack_ctrl_seq: multi-cycle Hack sequencer driving an external ALU; define ILLEGAL_TRAP_EN to trap C-instructions with ir[14:13] != 2'b11.
module hack_ctrl_seq #(
  parameter int              ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input logic            clk,
  input logic            rst,
  hack_ctrl_seq_if.master bus
);
`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, EXEC, MEM_WR, TRAP} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, EXEC, MEM_WR} state_t;
`endif
  state_t            state, next;
  logic [ADDR_W-1:0] pc, wa, pc_inc;
  logic [15:0]       a, d, ir, m, wd;
  logic              done, jmp, retired_q, bad;
  assign pc_inc = pc + 1'b1;
  assign jmp    = (ir[2] & bus.alu_ng) | (ir[1] & bus.alu_zr) | (ir[0] & ~bus.alu_ng & ~bus.alu_zr);
`ifdef ILLEGAL_TRAP_EN
  assign bad         = ir[14:13] != 2'b11;
  assign bus.illegal = state == TRAP;
`else
  assign bad         = 1'b0;
  assign bus.illegal = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? FETCH : next;
  always_comb begin
    next = state;
    done = 1'b0;
    case (state)
      FETCH:  next = bus.instr_valid ? DECODE : FETCH;
      DECODE: begin
        done = ~ir[15];
        next = ~ir[15] ? FETCH : ir[12] ? MEM_RD : EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (ir[15] && bad) next = TRAP;
`endif
      end
      MEM_RD: next = bus.mem_rd_ack ? EXEC : MEM_RD;
      EXEC: begin
        done = ~ir[3];
        next = ir[3] ? MEM_WR : FETCH;
      end
      MEM_WR: begin
        done = bus.mem_wr_ack;
        next = bus.mem_wr_ack ? FETCH : MEM_WR;
      end
      default: next = state;
    endcase
  end
  always_comb begin
    bus.instr_addr  = pc;
    bus.instr_ready = state == FETCH;
    bus.mem_rd_req  = state == MEM_RD;
    bus.mem_wr_req  = state == MEM_WR;
    bus.mem_addr    = state == MEM_WR ? wa : a[ADDR_W-1:0];
    bus.mem_wdata   = wd;
    bus.alu_x       = d;
    bus.alu_y       = ir[12] ? m : a;
    bus.alu_ctl     = state == EXEC ? ir[11:6] : 6'd0;
    bus.retired     = retired_q;
  end
  // Write address and jump target both take A as it was before EXEC updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      a         <= '0;
      d         <= '0;
      ir        <= '0;
      m         <= '0;
      wa        <= '0;
      wd        <= '0;
      retired_q <= 1'b0;
    end else begin
      retired_q <= done;
      if (state == FETCH && bus.instr_valid) ir <= bus.instr;
      if (state == DECODE && !ir[15]) begin
        a  <= {1'b0, ir[14:0]};
        pc <= pc_inc;
      end
      if (state == MEM_RD && bus.mem_rd_ack) m <= bus.mem_rdata;
      if (state == EXEC) begin
        if (ir[4]) d <= bus.alu_out;
        if (ir[5]) a <= bus.alu_out;
        wa <= a[ADDR_W-1:0];
        wd <= bus.alu_out;
        pc <= jmp ? a[ADDR_W-1:0] : pc_inc;
      end
    end
  end
endmodule

// File: tb/tb_hack_ctrl_seq.sv
// tb_hack_ctrl_seq: directed bench acting as ROM, RAM and combinational Hack ALU around hack_ctrl_seq.
module tb_hack_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] ax, ay, ao;
  always #5 clk = ~clk;
  hack_ctrl_seq_if #(.ADDR_W(15)) bus ();
  hack_ctrl_seq #(.ADDR_W(15), .PC_RESET(15'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_comb begin
    ax = bus.alu_ctl[5] ? 16'h0000 : bus.alu_x;
    ax = bus.alu_ctl[4] ? ~ax : ax;
    ay = bus.alu_ctl[3] ? 16'h0000 : bus.alu_y;
    ay = bus.alu_ctl[2] ? ~ay : ay;
    ao = bus.alu_ctl[1] ? ax + ay : ax & ay;
    ao = bus.alu_ctl[0] ? ~ao : ao;
  end
  assign bus.alu_out = ao;
  assign bus.alu_zr  = ao == 16'h0000;
  assign bus.alu_ng  = ao[15];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [15:0] w);
    chk("instr_ready", {15'd0, bus.instr_ready}, 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    step;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hFFFF;
  endtask

  task automatic a_instr(input logic [15:0] w);
    feed(w);
    chk("ready_in_decode", {15'd0, bus.instr_ready}, 16'd0);
    step;
    chk("retired_a", {15'd0, bus.retired}, 16'd1);
  endtask

  task automatic run_c(input logic [15:0] w);
    feed(w);
    step;
    chk("retired_exec", {15'd0, bus.retired}, 16'd0);
    step;
    chk("retired_c", {15'd0, bus.retired}, 16'd1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.mem_wr_ack  = 1'b0;
    step;
    step;
    rst = 1'b0;
    chk("rst_ready", {15'd0, bus.instr_ready}, 16'd1);
    chk("rst_pc", {1'b0, bus.instr_addr}, 16'h0000);
    chk("rst_rd_req", {15'd0, bus.mem_rd_req}, 16'd0);
    chk("rst_wr_req", {15'd0, bus.mem_wr_req}, 16'd0);
    chk("rst_retired", {15'd0, bus.retired}, 16'd0);
    chk("rst_illegal", {15'd0, bus.illegal}, 16'd0);
    chk("rst_alu_ctl", {10'd0, bus.alu_ctl}, 16'd0);
    // 1: @5 ; D=A
    a_instr(16'h0005);
    chk("t1_pc1", {1'b0, bus.instr_addr}, 16'h0001);
    feed(16'hEC10);
    chk("t1_decode_retired", {15'd0, bus.retired}, 16'd0);
    step;
    chk("t1_ctl", {10'd0, bus.alu_ctl}, 16'h0030);
    chk("t1_y", bus.alu_y, 16'h0005);
    chk("t1_x", bus.alu_x, 16'h0000);
    step;
    chk("t1_retired", {15'd0, bus.retired}, 16'd1);
    chk("t1_pc2", {1'b0, bus.instr_addr}, 16'h0002);
    // 2: @0x10 ; D=M with 3-cycle read
    a_instr(16'h0010);
    feed(16'hFC10);
    step;
    chk("t2_req0", {15'd0, bus.mem_rd_req}, 16'd1);
    chk("t2_addr", {1'b0, bus.mem_addr}, 16'h0010);
    chk("t2_ctl_rd", {10'd0, bus.alu_ctl}, 16'd0);
    step;
    chk("t2_req1", {15'd0, bus.mem_rd_req}, 16'd1);
    step;
    chk("t2_req2", {15'd0, bus.mem_rd_req}, 16'd1);
    bus.mem_rd_ack = 1'b1;
    bus.mem_rdata  = 16'h1234;
    step;
    bus.mem_rd_ack = 1'b0;
    chk("t2_req_drop", {15'd0, bus.mem_rd_req}, 16'd0);
    chk("t2_x_is_d", bus.alu_x, 16'h0005);
    chk("t2_y_is_m", bus.alu_y, 16'h1234);
    step;
    chk("t2_pc", {1'b0, bus.instr_addr}, 16'h0004);
    // 3: D=0x7FFF, @0x20 ; M=D+1
    a_instr(16'h7FFF);
    feed(16'hEC10);
    step;
    chk("t3_y", bus.alu_y, 16'h7FFF);
    step;
    a_instr(16'h0020);
    feed(16'hE7C8);
    step;
    chk("t3_x", bus.alu_x, 16'h7FFF);
    chk("t3_ctl", {10'd0, bus.alu_ctl}, 16'h001F);
    step;
    chk("t3_wr_req", {15'd0, bus.mem_wr_req}, 16'd1);
    chk("t3_wr_addr", {1'b0, bus.mem_addr}, 16'h0020);
    chk("t3_wdata", bus.mem_wdata, 16'h8000);
    chk("t3_no_retire", {15'd0, bus.retired}, 16'd0);
    step;
    chk("t3_wr_hold", {15'd0, bus.mem_wr_req}, 16'd1);
    bus.mem_wr_ack = 1'b1;
    step;
    bus.mem_wr_ack = 1'b0;
    chk("t3_retired", {15'd0, bus.retired}, 16'd1);
    chk("t3_wr_drop", {15'd0, bus.mem_wr_req}, 16'd0);
    chk("t3_pc", {1'b0, bus.instr_addr}, 16'h0008);
    // 4: D=0, @0x100 ; D;JEQ taken, D;JGT not taken
    run_c(16'hEA90);
    a_instr(16'h0100);
    feed(16'hE302);
    step;
    chk("t4_ctl", {10'd0, bus.alu_ctl}, 16'h000C);
    chk("t4_x", bus.alu_x, 16'h0000);
    step;
    chk("t4_jeq", {1'b0, bus.instr_addr}, 16'h0100);
    run_c(16'hE301);
    chk("t4_jgt", {1'b0, bus.instr_addr}, 16'h0101);
    // A=-1;JMP jumps to the old A
    a_instr(16'h0200);
    run_c(16'hEEA7);
    chk("t4_old_a_jump", {1'b0, bus.instr_addr}, 16'h0200);
    feed(16'hEC10);
    step;
    chk("t4_new_a", bus.alu_y, 16'hFFFF);
    step;
    chk("t4_pc_after", {1'b0, bus.instr_addr}, 16'h0201);
    // PC wraps from 0x7FFF to 0
    a_instr(16'h7FFF);
    run_c(16'hEA87);
    chk("wrap_jmp", {1'b0, bus.instr_addr}, 16'h7FFF);
    a_instr(16'h0001);
    chk("wrap_pc", {1'b0, bus.instr_addr}, 16'h0000);
    // 5: reset during a read wait, late ack ignored
    a_instr(16'h0030);
    feed(16'hFC10);
    step;
    chk("t5_req", {15'd0, bus.mem_rd_req}, 16'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t5_req_drop", {15'd0, bus.mem_rd_req}, 16'd0);
    chk("t5_ready", {15'd0, bus.instr_ready}, 16'd1);
    chk("t5_pc", {1'b0, bus.instr_addr}, 16'h0000);
    bus.mem_rd_ack = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    step;
    bus.mem_rd_ack = 1'b0;
    chk("t5_late_ack_req", {15'd0, bus.mem_rd_req}, 16'd0);
    chk("t5_late_ack_ready", {15'd0, bus.instr_ready}, 16'd1);
    chk("t5_late_ack_pc", {1'b0, bus.instr_addr}, 16'h0000);
    // 0-wait read after reset; D was cleared
    a_instr(16'h0050);
    feed(16'hFC10);
    step;
    chk("t5_req0w", {15'd0, bus.mem_rd_req}, 16'd1);
    bus.mem_rd_ack = 1'b1;
    bus.mem_rdata  = 16'hBEEF;
    step;
    bus.mem_rd_ack = 1'b0;
    chk("t5_m0w", bus.alu_y, 16'hBEEF);
    chk("t5_d_reset", bus.alu_x, 16'h0000);
    step;
    chk("t5_pc2", {1'b0, bus.instr_addr}, 16'h0002);
    // 6: 0x9000 with ir[14:13]=00
    feed(16'h9000);
    step;
`ifdef ILLEGAL_TRAP_EN
    chk("t6_illegal", {15'd0, bus.illegal}, 16'd1);
    chk("t6_ready", {15'd0, bus.instr_ready}, 16'd0);
    step;
    step;
    step;
    chk("t6_illegal_hold", {15'd0, bus.illegal}, 16'd1);
    chk("t6_ready_hold", {15'd0, bus.instr_ready}, 16'd0);
    chk("t6_pc_hold", {1'b0, bus.instr_addr}, 16'h0002);
`else
    chk("t6_illegal", {15'd0, bus.illegal}, 16'd0);
    chk("t6_rd_req", {15'd0, bus.mem_rd_req}, 16'd1);
    chk("t6_rd_addr", {1'b0, bus.mem_addr}, 16'h0050);
    bus.mem_rd_ack = 1'b1;
    bus.mem_rdata  = 16'h0000;
    step;
    bus.mem_rd_ack = 1'b0;
    chk("t6_ctl", {10'd0, bus.alu_ctl}, 16'h0000);
    step;
    chk("t6_retired", {15'd0, bus.retired}, 16'd1);
    chk("t6_pc", {1'b0, bus.instr_addr}, 16'h0003);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
